cond_stage: RTL and testbench
=============================

# cond_stage

Execute-to-memory stage directly downstream of the ALU in the 32-bit ARM-style core. Holds the architectural NZCV flag register. Evaluates each instruction's 4-bit condition code against the current flags and conditionally commits the ALU's new flags. Registers the ALU result and the condition-gated write controls into the EX/MEM pipeline register behind a valid/ready handshake.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kills the stage contents and the incoming instruction
- in_valid  in  1  ALU-side instruction valid
- in_ready  out  1  stage can accept; in_ready = !out_valid | out_ready
- cond  in  4  ARM condition field (EQ=0000 … AL=1110)
- flag_w  in  2  flag write enables; [1] updates N,Z; [0] updates C,V
- reg_w, mem_w, pc_s, no_write  in  1 each  decoded controls (no_write marks CMP/TST-class instructions)
- alu_result  in  32  ALU result
- alu_flags  in  4  {N,Z,C,V} from the ALU, stored as-is
- write_data  in  32  store data
- wa  in  4  destination register
- out_valid  out  1  EX/MEM register holds a valid instruction
- out_ready  in  1  downstream accepts
- out_alu_result, out_write_data  out  32  registered copies
- out_wa  out  4  registered destination
- out_reg_w, out_mem_w, out_pc_s  out  1 each  condition-gated controls
- out_cond_ex  out  1  registered condition outcome
- flags  out  4  current flag register {N,Z,C,V}
- exec_cnt, squash_cnt  out  32 each  performance counters (see Configuration)

## Operation
- Accept occurs when in_valid & in_ready & !flush.
- On accept, cond_ex is computed from the flags register value *before* this instruction's update:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 is treated as AL
- Flag update on accept, only when cond_ex = 1:
  - flag_w[1] loads N,Z from alu_flags[3:2]
  - flag_w[0] loads C,V from alu_flags[1:0]
  - The two halves update independently.
- Output register on accept:
  - out_reg_w = reg_w & cond_ex & !no_write
  - out_mem_w = mem_w & cond_ex
  - out_pc_s = pc_s & cond_ex
  - Data and wa are copied unconditionally.
  - out_valid is set to 1. A squashed instruction still advances, with zeroed controls.
- If out_valid & out_ready and there is no accept, out_valid clears.
- Stall (out_valid & !out_ready):
  - All out_* signals hold.
  - in_ready is 0.
  - Flags do not change.
- flush:
  - Next edge sets out_valid = 0.
  - The incoming instruction is dropped; no flag or counter update.
  - Flush has priority over both accept and stall.
- Reset values:
  - flags = 0000, out_valid = 0
  - All out_* data and controls = 0
  - exec_cnt = squash_cnt = 0
- Reset asserted mid-operation discards the in-flight instruction immediately (asynchronously).

## Timing
- Latency is 1 cycle: an instruction accepted at edge k appears on out_* after edge k.
- A flag update from the instruction accepted at edge k is visible on flags after edge k. It is used by the condition check of the instruction accepted at edge k+1. No bypass is needed or present.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_valid.
- Full throughput is one instruction per cycle while out_ready = 1.

## Configuration
- COND_PERF_CNT_EN defined:
  - exec_cnt increments on each accept with cond_ex = 1.
  - squash_cnt increments on each accept with cond_ex = 0.
  - Both are 32-bit, wrap from FFFFFFFF to 0, and are not incremented on flush.
- COND_PERF_CNT_EN undefined:
  - exec_cnt and squash_cnt are driven constant 0.
  - No counter flops are present.
  - All other behaviour is identical.

## Test plan
- Reset, then accept cond=AL, flag_w=11, alu_flags=0100 → flags=0100 after 1 edge. The next instruction with cond=EQ has out_cond_ex=1 and out_reg_w=reg_w; with cond=NE it has out_reg_w=0.
- Partial update: flags=1010, accept AL with flag_w=01, alu_flags=0101 → flags=1001.
- Squashed flag-setter: flags=0000, accept cond=EQ, flag_w=11, alu_flags=0100 → flags stay 0000, out_valid=1, all gated controls 0, squash_cnt +1.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* and flags unchanged. Raising out_ready accepts the waiting instruction on the next edge.
- Flush with simultaneous accept of a flag-setter → out_valid=0, flags unchanged, counters unchanged.
- Counter wrap (COND_PERF_CNT_EN): force exec_cnt=FFFFFFFF, accept AL → exec_cnt=00000000.

Source files
------------

// File: rtl/cond_stage.sv
// cond_stage: execute-to-memory stage behind the ALU.
// Owns the architectural NZCV flag register, evaluates each instruction's
// condition code against it, commits the ALU flags for executed instructions
// and registers the result plus condition-gated write controls into EX/MEM.
// Optional build macro: COND_PERF_CNT_EN adds exec/squash performance counters;
// without it exec_cnt and squash_cnt are tied to zero.
module cond_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic [1:0]  flag_w,
    input  logic        reg_w,
    input  logic        mem_w,
    input  logic        pc_s,
    input  logic        no_write,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    input  logic [31:0] write_data,
    input  logic [3:0]  wa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_alu_result,
    output logic [31:0] out_write_data,
    output logic [3:0]  out_wa,
    output logic        out_reg_w,
    output logic        out_mem_w,
    output logic        out_pc_s,
    output logic        out_cond_ex,
    output logic [3:0]  flags,
    output logic [31:0] exec_cnt,
    output logic [31:0] squash_cnt
);

    // Handshake: a transfer on either side happens on a rising edge where that
    // side's valid and ready are both high; once out_valid is raised, it and the
    // whole out_* payload hold until out_ready is seen high. in_ready depends
    // only on out_valid/out_ready, never on in_valid. flush overrides everything.

    logic [3:0] flags_q;
    logic       cond_ex;
    logic       accept;
    logic       f_n;
    logic       f_z;
    logic       f_c;
    logic       f_v;

    assign {f_n, f_z, f_c, f_v} = flags_q;
    assign flags    = flags_q;
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready & !flush;

    // Condition check against the committed flags (no bypass from this instruction)
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            4'b0000: cond_ex = f_z;
            4'b0001: cond_ex = !f_z;
            4'b0010: cond_ex = f_c;
            4'b0011: cond_ex = !f_c;
            4'b0100: cond_ex = f_n;
            4'b0101: cond_ex = !f_n;
            4'b0110: cond_ex = f_v;
            4'b0111: cond_ex = !f_v;
            4'b1000: cond_ex = f_c & !f_z;
            4'b1001: cond_ex = !f_c | f_z;
            4'b1010: cond_ex = (f_n == f_v);
            4'b1011: cond_ex = (f_n != f_v);
            4'b1100: cond_ex = !f_z & (f_n == f_v);
            4'b1101: cond_ex = f_z | (f_n != f_v);
            default: cond_ex = 1'b1;  // AL, and 1111 behaves as AL
        endcase
    end

    // Flag register: N/Z and C/V halves commit independently for executed instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (accept && cond_ex) begin
            if (flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
            if (flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
        end
    end

    // EX/MEM register: load on accept, drain on downstream take, kill on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_alu_result <= 32'h0;
            out_write_data <= 32'h0;
            out_wa         <= 4'h0;
            out_reg_w      <= 1'b0;
            out_mem_w      <= 1'b0;
            out_pc_s       <= 1'b0;
            out_cond_ex    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_alu_result <= alu_result;
            out_write_data <= write_data;
            out_wa         <= wa;
            out_reg_w      <= reg_w & cond_ex & !no_write;
            out_mem_w      <= mem_w & cond_ex;
            out_pc_s       <= pc_s & cond_ex;
            out_cond_ex    <= cond_ex;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [31:0] exec_cnt_q;
    logic [31:0] squash_cnt_q;

    // Performance counters: executed vs squashed accepts, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt_q   <= 32'h0;
            squash_cnt_q <= 32'h0;
        end else if (accept) begin
            if (cond_ex) exec_cnt_q   <= exec_cnt_q + 32'd1;
            else         squash_cnt_q <= squash_cnt_q + 32'd1;
        end
    end

    assign exec_cnt   = exec_cnt_q;
    assign squash_cnt = squash_cnt_q;
`else
    assign exec_cnt   = 32'h0;
    assign squash_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_cond_stage.sv
// tb_cond_stage: self-checking bench for cond_stage.
// Honours COND_PERF_CNT_EN the same way the design does.
module tb_cond_stage;

    localparam int EXP_W = 72;
`ifdef COND_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [3:0] C_EQ = 4'h0;
    localparam logic [3:0] C_NE = 4'h1;
    localparam logic [3:0] C_AL = 4'hE;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic [1:0]  flag_w;
    logic        reg_w;
    logic        mem_w;
    logic        pc_s;
    logic        no_write;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [31:0] write_data;
    logic [3:0]  wa;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_write_data;
    logic [3:0]  out_wa;
    logic        out_reg_w;
    logic        out_mem_w;
    logic        out_pc_s;
    logic        out_cond_ex;
    logic [3:0]  flags;
    logic [31:0] exec_cnt;
    logic [31:0] squash_cnt;

    logic [EXP_W-1:0] out_payload;
    assign out_payload = {out_alu_result, out_write_data, out_wa,
                          out_reg_w, out_mem_w, out_pc_s, out_cond_ex};

    // scoreboard and reference model state
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] last_exp;
    logic [3:0]       m_flags;
    logic             m_valid;
    logic [31:0]      m_exec;
    logic [31:0]      m_squash;
    int               checks;
    int               errors;

    cond_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .cond           (cond),
        .flag_w         (flag_w),
        .reg_w          (reg_w),
        .mem_w          (mem_w),
        .pc_s           (pc_s),
        .no_write       (no_write),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags),
        .write_data     (write_data),
        .wa             (wa),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_write_data (out_write_data),
        .out_wa         (out_wa),
        .out_reg_w      (out_reg_w),
        .out_mem_w      (out_mem_w),
        .out_pc_s       (out_pc_s),
        .out_cond_ex    (out_cond_ex),
        .flags          (flags),
        .exec_cnt       (exec_cnt),
        .squash_cnt     (squash_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference condition evaluation: pairs of conditions are complements
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        base = 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & !z;
            3'd5: base = (n == v);
            3'd6: base = !z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    function automatic void model_reset();
        m_flags  = 4'h0;
        m_valid  = 1'b0;
        m_exec   = 32'h0;
        m_squash = 32'h0;
        last_exp = '0;
        exp_q.delete();
    endfunction

    // driver + scoreboard: presents one instruction for one edge, then checks
    task automatic drive_instr(input logic [3:0] c, input logic [1:0] fw,
                               input logic [3:0] af, input logic [3:0] ctl,
                               input logic fl, input logic ordy);
        logic acc, ce, exp_rdy, hold;
        logic [EXP_W-1:0] e;
        logic [31:0] res, wd;
        logic [3:0]  w;
        res = $urandom;
        wd  = $urandom;
        w   = 4'($urandom_range(0, 15));
        cond = c; flag_w = fw; alu_flags = af;
        {reg_w, mem_w, pc_s, no_write} = ctl;
        flush = fl; out_ready = ordy;
        alu_result = res; write_data = wd; wa = w;
        in_valid = 1'b1;
        #1;
        exp_rdy = !m_valid | ordy;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready got %b want %b", in_ready, exp_rdy);
        end
        acc  = exp_rdy & !fl;
        hold = m_valid & !ordy & !fl;
        ce   = cond_model(c, m_flags);
        if (acc) begin
            e = {res, wd, w, ctl[3] & ce & !ctl[0], ctl[2] & ce, ctl[1] & ce, ce};
            exp_q.push_back(e);
            if (ce) begin
                if (fw[1]) m_flags[3:2] = af[3:2];
                if (fw[0]) m_flags[1:0] = af[1:0];
                m_exec = m_exec + 32'd1;
            end else begin
                m_squash = m_squash + 32'd1;
            end
        end
        if (fl)        m_valid = 1'b0;
        else if (acc)  m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid got %b want %b", out_valid, m_valid);
        end
        if (acc && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_exp = e;
            checks++;
            if (out_payload !== e) begin
                errors++;
                $display("FAIL out_payload got %h want %h", out_payload, e);
            end
        end else if (hold) begin
            checks++;
            if (out_payload !== last_exp) begin
                errors++;
                $display("FAIL stall_hold got %h want %h", out_payload, last_exp);
            end
        end
        checks++;
        if (flags !== m_flags) begin
            errors++;
            $display("FAIL flags got %b want %b", flags, m_flags);
        end
        checks++;
        if (exec_cnt !== (PERF ? m_exec : 32'h0)) begin
            errors++;
            $display("FAIL exec_cnt got %h want %h", exec_cnt, PERF ? m_exec : 32'h0);
        end
        checks++;
        if (squash_cnt !== (PERF ? m_squash : 32'h0)) begin
            errors++;
            $display("FAIL squash_cnt got %h want %h", squash_cnt, PERF ? m_squash : 32'h0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cond = 4'h0; flag_w = 2'b00; reg_w = 1'b0; mem_w = 1'b0; pc_s = 1'b0;
        no_write = 1'b0; alu_result = 32'h0; alu_flags = 4'h0; write_data = 32'h0; wa = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (out_payload !== '0) begin errors++; $display("FAIL reset_payload got %h want 0", out_payload); end
        checks++;
        if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
        checks++;
        if (exec_cnt !== 32'h0 || squash_cnt !== 32'h0) begin
            errors++; $display("FAIL reset_cnt got %h/%h want 0/0", exec_cnt, squash_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_cond_flags();
        drive_instr(C_AL, 2'b11, 4'b0100, 4'b0000, 1'b0, 1'b1);
        checks++;
        if (flags !== 4'b0100) begin errors++; $display("FAIL al_flags got %b want 0100", flags); end
        drive_instr(C_EQ, 2'b00, 4'h0, 4'b1000, 1'b0, 1'b1);
        checks++;
        if (out_cond_ex !== 1'b1 || out_reg_w !== 1'b1) begin
            errors++; $display("FAIL eq_exec got %b%b want 11", out_cond_ex, out_reg_w);
        end
        drive_instr(C_NE, 2'b00, 4'h0, 4'b1000, 1'b0, 1'b1);
        checks++;
        if (out_reg_w !== 1'b0) begin errors++; $display("FAIL ne_reg_w got %b want 0", out_reg_w); end
        // no_write suppresses reg_w even when executed
        drive_instr(C_EQ, 2'b00, 4'h0, 4'b1111, 1'b0, 1'b1);
    endtask

    task automatic test_partial_update();
        drive_instr(C_AL, 2'b11, 4'b1010, 4'b0000, 1'b0, 1'b1);
        drive_instr(C_AL, 2'b01, 4'b0101, 4'b0000, 1'b0, 1'b1);
        checks++;
        if (flags !== 4'b1001) begin errors++; $display("FAIL partial_cv got %b want 1001", flags); end
        drive_instr(C_AL, 2'b10, 4'b0111, 4'b0000, 1'b0, 1'b1);
        checks++;
        if (flags !== 4'b0101) begin errors++; $display("FAIL partial_nz got %b want 0101", flags); end
    endtask

    task automatic test_squash();
        logic [31:0] sq_before;
        drive_instr(C_AL, 2'b11, 4'b0000, 4'b0000, 1'b0, 1'b1);
        sq_before = m_squash;
        drive_instr(C_EQ, 2'b11, 4'b0100, 4'b1110, 1'b0, 1'b1);
        checks++;
        if (flags !== 4'b0000 || out_valid !== 1'b1 ||
            {out_reg_w, out_mem_w, out_pc_s, out_cond_ex} !== 4'b0000) begin
            errors++;
            $display("FAIL squash got flags=%b v=%b ctl=%b%b%b%b want 0000 1 0000",
                     flags, out_valid, out_reg_w, out_mem_w, out_pc_s, out_cond_ex);
        end
        checks++;
        if (m_squash !== sq_before + 32'd1) begin
            errors++; $display("FAIL squash_model got %h want %h", m_squash, sq_before + 32'd1);
        end
    endtask

    task automatic test_stall();
        drive_instr(C_AL, 2'b11, 4'b0000, 4'b1110, 1'b0, 1'b1);
        repeat (3) drive_instr(C_AL, 2'b11, 4'b1111, 4'b1110, 1'b0, 1'b0);
        checks++;
        if (flags !== 4'b0000) begin errors++; $display("FAIL stall_flags got %b want 0000", flags); end
        drive_instr(C_AL, 2'b11, 4'b1111, 4'b1110, 1'b0, 1'b1);
        checks++;
        if (flags !== 4'b1111) begin errors++; $display("FAIL stall_release got %b want 1111", flags); end
    endtask

    task automatic test_flush();
        drive_instr(C_AL, 2'b11, 4'b0000, 4'b1110, 1'b0, 1'b1);
        drive_instr(C_AL, 2'b11, 4'b1111, 4'b1110, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || flags !== 4'b0000) begin
            errors++; $display("FAIL flush_accept got v=%b flags=%b want 0 0000", out_valid, flags);
        end
        // flush during a stall also empties the stage
        drive_instr(C_AL, 2'b00, 4'b0000, 4'b1110, 1'b0, 1'b1);
        drive_instr(C_AL, 2'b11, 4'b1111, 4'b1110, 1'b1, 1'b0);
    endtask

    task automatic test_cond_table();
        logic [3:0] fv;
        for (int i = 0; i < 16; i++) begin
            fv = 4'(i);
            drive_instr(C_AL, 2'b11, fv, 4'b0000, 1'b0, 1'b1);
            for (int c = 0; c < 16; c++)
                drive_instr(4'(c), 2'b00, 4'h0, 4'b1110, 1'b0, 1'b1);
        end
    endtask

    task automatic test_async_reset();
        drive_instr(C_AL, 2'b11, 4'b1011, 4'b1110, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || flags !== 4'h0 || out_payload !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%b flags=%b payload=%h want 0", out_valid, flags, out_payload);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            drive_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 11) == 0), (i < 50) || ($urandom_range(0, 3) != 0));
        end
    endtask

`ifdef COND_PERF_CNT_EN
    task automatic test_counter_wrap();
        dut.exec_cnt_q = 32'hFFFF_FFFF;
        m_exec = 32'hFFFF_FFFF;
        drive_instr(C_AL, 2'b00, 4'h0, 4'b0000, 1'b0, 1'b1);
        checks++;
        if (exec_cnt !== 32'h0) begin errors++; $display("FAIL exec_wrap got %h want 0", exec_cnt); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cond_flags();
        test_partial_update();
        test_squash();
        test_stall();
        test_flush();
        test_cond_table();
        test_async_reset();
        test_back_to_back();
`ifdef COND_PERF_CNT_EN
        test_counter_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
